// File: rtl/odd_sequence_checker.sv
// odd_sequence_checker: monitors the odd-value counter's state/Y stream.
// Locks onto the legal sequence 0,1,3,5,7,9,11,1,3,..., flags and counts
// breaks while locked, counts 11->1 laps, and pulses on Y/state mismatches.
module odd_sequence_checker #(
  parameter int LOCK_THRESHOLD = 3,
  parameter int ERR_CNT_W      = 8,
  parameter int LAP_CNT_W      = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic [3:0]           count_in,
  input  logic                 y_in,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [LAP_CNT_W-1:0] lap_count,
  output logic                 y_mismatch,
  output logic [1:0]           state_out
);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    LOCKED = 2'b01,
    ERROR  = 2'b10
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] prev;
  logic       prev_valid;
  logic [3:0] run;

  logic [3:0] exp_val;
  logic       exp_ok;
  logic       good, bad, wrap, run_hit;

  // Expected successor of the previous sample; values off the sequence have none.
  always_comb begin
    exp_ok  = 1'b1;
    exp_val = 4'd0;
    case (prev)
      4'd0:                         exp_val = 4'd1;
      4'd1, 4'd3, 4'd5, 4'd7, 4'd9: exp_val = prev + 4'd2;
      4'd11:                        exp_val = 4'd1;
      default:                      exp_ok  = 1'b0;
    endcase
  end

  assign good    = prev_valid & exp_ok & (count_in == exp_val);
  assign bad     = prev_valid & ~good;
  assign wrap    = (prev == 4'd11) & (count_in == 4'd1);
  assign run_hit = (({1'b0, run} + 5'd1) == 5'(LOCK_THRESHOLD));

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= HUNT;
    else        state <= state_nxt;
  end

  // Next state. ERROR always lasts a single clock, even if en is low,
  // so the break is visible for exactly one cycle on state_out.
  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:    if (en && good && run_hit) state_nxt = LOCKED;
      LOCKED:  if (en && bad)             state_nxt = ERROR;
      ERROR:   state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  // Outputs decoded straight from the state register.
  always_comb begin
    locked    = (state == LOCKED);
    state_out = state;
  end

  // Sample history, lock run length, pulses and saturating counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev       <= 4'd0;
      prev_valid <= 1'b0;
      run        <= 4'd0;
      err_pulse  <= 1'b0;
      y_mismatch <= 1'b0;
      err_count  <= '0;
      lap_count  <= '0;
    end else begin
      err_pulse  <= 1'b0;
      y_mismatch <= 1'b0;
      if (state == ERROR) run <= 4'd0;
      if (en) begin
        prev       <= count_in;
        prev_valid <= 1'b1;
        y_mismatch <= (y_in != (count_in == 4'd3));
        case (state)
          HUNT: begin
            if (good)     run <= run_hit ? 4'd0 : run + 4'd1;
            else if (bad) run <= 4'd0;
          end
          LOCKED: begin
            if (good && wrap && (lap_count != '1)) lap_count <= lap_count + 1'b1;
            if (bad) begin
              err_pulse <= 1'b1;
              if (err_count != '1) err_count <= err_count + 1'b1;
            end
          end
          default: ;  // ERROR: sample only reloads prev
        endcase
      end
    end
  end

endmodule
